// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//   Scans a 4x4 matrix keypad with a rotating one-cold column drive and
//   hands press/release qualification to an external debouncer.
//   The debouncer answers through high/low. A confirmed press is reported
//   as a hex key code with a one-clock keyValid strobe. keyHeld stays high
//   until the release is confirmed.
//
// Ports
//   clk        in   system clock, rising edge
//   rstn       in   asynchronous active-low reset
//   en         in   scan/step tick; the FSM and column rotation advance only when en=1
//   sense      in   [3:0] raw row lines, active-high, asynchronous to clk
//   senseSync  out  [3:0] synchronised row lines, also the debouncer input
//   activeCol  out  [3:0] one-cold column drive; the low bit is the driven column
//   req        out  debounce request, high from press detect through release
//   high       in   debouncer: stable-high (press) confirmed
//   low        in   debouncer: stable-low (release/bounce-off) confirmed
//   key        out  [3:0] hex code of the last confirmed key
//   keyValid   out  one-clock pulse on a newly confirmed press
//   keyHeld    out  high while the confirmed key is not yet released
// ---------------------------------------------------------------------------
module keypad_scanner (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic [3:0] sense,
    output logic [3:0] senseSync,
    output logic [3:0] activeCol,
    output logic       req,
    input  logic       high,
    input  logic       low,
    output logic [3:0] key,
    output logic       keyValid,
    output logic       keyHeld
);

    localparam int unsigned ROW_W = 4;
    localparam int unsigned COL_W = 4;
    localparam int unsigned KEY_W = 4;
    localparam int unsigned IDX_W = 2;

    localparam logic [COL_W-1:0] COL_RESET = COL_W'(4'b1110);

    typedef enum logic [1:0] {
        ST_SCAN    = 2'd0,
        ST_PRESS   = 2'd1,
        ST_HELD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    // Index of the lowest set row bit; lower rows take priority.
    function automatic logic [IDX_W-1:0] lowest_row(input logic [ROW_W-1:0] rows);
        logic [IDX_W-1:0] idx;
        idx = IDX_W'(0);
        for (int i = ROW_W - 1; i >= 0; i--) begin
            if (rows[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // Column index of the single low bit in a one-cold drive pattern.
    function automatic logic [IDX_W-1:0] col_index(input logic [COL_W-1:0] col);
        logic [IDX_W-1:0] idx;
        case (col)
            4'b1110: idx = IDX_W'(0);
            4'b1101: idx = IDX_W'(1);
            4'b1011: idx = IDX_W'(2);
            4'b0111: idx = IDX_W'(3);
            default: idx = IDX_W'(0);
        endcase
        return idx;
    endfunction

    // Keypad legend: row-major, columns 0..3 within each row.
    function automatic logic [KEY_W-1:0] key_map(input logic [IDX_W-1:0] r,
                                                 input logic [IDX_W-1:0] c);
        logic [KEY_W-1:0] code;
        case ({r, c})
            4'h0: code = KEY_W'(4'h1);
            4'h1: code = KEY_W'(4'h2);
            4'h2: code = KEY_W'(4'h3);
            4'h3: code = KEY_W'(4'hA);
            4'h4: code = KEY_W'(4'h4);
            4'h5: code = KEY_W'(4'h5);
            4'h6: code = KEY_W'(4'h6);
            4'h7: code = KEY_W'(4'hB);
            4'h8: code = KEY_W'(4'h7);
            4'h9: code = KEY_W'(4'h8);
            4'hA: code = KEY_W'(4'h9);
            4'hB: code = KEY_W'(4'hC);
            4'hC: code = KEY_W'(4'hE);
            4'hD: code = KEY_W'(4'h0);
            4'hE: code = KEY_W'(4'hF);
            default: code = KEY_W'(4'hD);
        endcase
        return code;
    endfunction

    state_e           state_q, state_d;
    logic [ROW_W-1:0] sync1_q, sync2_q;
    logic [COL_W-1:0] col_q, col_d;
    logic [IDX_W-1:0] row_q, row_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;
    logic             req_q, req_d;

    // Two-flop synchroniser for the asynchronous row lines, free-running.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sense;
            sync2_q <= sync1_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_SCAN;
            col_q       <= COL_RESET;
            row_q       <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            req_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            req_q       <= req_d;
        end
    end

    // Next-state and registered-output logic; everything holds unless en ticks.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        key_d       = key_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        req_d       = req_q;

        if (en) begin
            case (state_q)
                ST_SCAN: begin
                    if (sync2_q != '0) begin
                        // Freeze the column and remember which row fired.
                        row_d   = lowest_row(sync2_q);
                        req_d   = 1'b1;
                        state_d = ST_PRESS;
                    end else begin
                        col_d = {col_q[COL_W-2:0], col_q[COL_W-1]};
                    end
                end
                ST_PRESS: begin
                    // A confirmed press outranks a simultaneous bounce-off.
                    if (high) begin
                        key_d       = key_map(row_q, col_index(col_q));
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                        state_d     = ST_HELD;
                    end else if (low) begin
                        req_d   = 1'b0;
                        state_d = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    if (sync2_q == '0) begin
                        state_d = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    // Re-press takes priority here too; the key is not re-reported.
                    if (high) begin
                        state_d = ST_HELD;
                    end else if (low) begin
                        key_held_d = 1'b0;
                        req_d      = 1'b0;
                        state_d    = ST_SCAN;
                    end
                end
                default: begin
                    state_d = ST_SCAN;
                end
            endcase
        end
    end

    assign senseSync = sync2_q;
    assign activeCol = col_q;
    assign req       = req_q;
    assign key       = key_q;
    assign keyValid  = key_valid_q;
    assign keyHeld   = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner
//   Directed scenarios followed by randomised stimulus, each cycle checked
//   against a behavioural model of the scanner built from the keypad
//   legend, a column counter and a row-sample history.
// ---------------------------------------------------------------------------
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rstn;
    logic       en;
    logic [3:0] sense;
    logic [3:0] senseSync;
    logic [3:0] activeCol;
    logic       req;
    logic       high;
    logic       low;
    logic [3:0] key;
    logic       keyValid;
    logic       keyHeld;

    int n_checks = 0;
    int n_errors = 0;

    keypad_scanner dut (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .sense     (sense),
        .senseSync (senseSync),
        .activeCol (activeCol),
        .req       (req),
        .high      (high),
        .low       (low),
        .key       (key),
        .keyValid  (keyValid),
        .keyHeld   (keyHeld)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    localparam int M_SCAN = 0, M_PRESS = 1, M_HELD = 2, M_RELEASE = 3;

    logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};

    int         m_mode;
    int         m_c;
    int         m_r;
    logic [3:0] m_hist [2];   // [0] first sample, [1] synchronised sample
    logic [3:0] m_key;
    logic       m_kv;
    logic       prev_kv;

    task automatic model_reset();
        m_mode    = M_SCAN;
        m_c       = 0;
        m_r       = 0;
        m_hist[0] = 4'h0;
        m_hist[1] = 4'h0;
        m_key     = 4'h0;
        m_kv      = 1'b0;
        prev_kv   = 1'b0;
    endtask

    task automatic model_edge(input logic e, input logic [3:0] s,
                              input logic h, input logic l);
        logic [3:0] seen;
        seen      = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = s;
        m_kv      = 1'b0;
        if (e) begin
            case (m_mode)
                M_SCAN: begin
                    if (seen != 4'h0) begin
                        for (int i = 3; i >= 0; i--) if (seen[i]) m_r = i;
                        m_mode = M_PRESS;
                    end else begin
                        m_c = (m_c + 1) % 4;
                    end
                end
                M_PRESS: begin
                    if (h) begin
                        m_key  = keymap[m_r * 4 + m_c];
                        m_kv   = 1'b1;
                        m_mode = M_HELD;
                    end else if (l) begin
                        m_mode = M_SCAN;
                    end
                end
                M_HELD: if (seen == 4'h0) m_mode = M_RELEASE;
                default: begin
                    if (h)      m_mode = M_HELD;
                    else if (l) m_mode = M_SCAN;
                end
            endcase
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] exp_col;
        exp_col = 4'hF ^ (4'h1 << m_c);
        chk({tag, ".senseSync"}, senseSync, m_hist[1]);
        chk({tag, ".activeCol"}, activeCol, exp_col);
        chk({tag, ".req"},       {3'b0, req},      {3'b0, m_mode != M_SCAN});
        chk({tag, ".key"},       key, m_key);
        chk({tag, ".keyValid"},  {3'b0, keyValid}, {3'b0, m_kv});
        chk({tag, ".keyHeld"},   {3'b0, keyHeld},
            {3'b0, (m_mode == M_HELD) || (m_mode == M_RELEASE)});
        chk({tag, ".kv_repeat"}, {3'b0, keyValid & prev_kv}, 4'h0);
        prev_kv = keyValid;
    endtask

    // One clock: drive on the falling edge, check 1 time unit after the rising edge.
    task automatic step(input string tag, input logic e, input logic [3:0] s,
                        input logic h, input logic l);
        @(negedge clk);
        en = e; sense = s; high = h; low = l;
        @(posedge clk);
        model_edge(e, s, h, l);
        #1;
        check_all(tag);
    endtask

    // Reset asserted between clock edges; outputs must clear without a clock.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        en = 1'b0; sense = 4'h0; high = 1'b0; low = 1'b0;
        rstn = 1'b0;
        #1;
        model_reset();
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        check_all({tag, ".hold"});
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] rs;
        logic       re, rh, rl;

        rstn = 1'b1; en = 1'b0; sense = 4'h0; high = 1'b0; low = 1'b0;
        model_reset();
        #3;
        do_reset("reset");

        // Idle rotation, 8 en ticks.
        for (int i = 0; i < 8; i++) step("idle", 1'b1, 4'h0, 1'b0, 1'b0);
        chk("idle_wrap", activeCol, 4'b1110);

        // Advance to column 2, then press row 1 there.
        step("to_c1", 1'b1, 4'h0, 1'b0, 1'b0);
        step("to_c2", 1'b1, 4'h0, 1'b0, 1'b0);
        chk("at_c2", activeCol, 4'b1011);
        step("sync_a", 1'b0, 4'b0010, 1'b0, 1'b0);
        step("sync_b", 1'b0, 4'b0010, 1'b0, 1'b0);
        step("detect", 1'b1, 4'b0010, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step("debounce", 1'b1, 4'b0010, 1'b0, 1'b0);
        step("confirm", 1'b1, 4'b0010, 1'b1, 1'b0);
        chk("key6", key, 4'h6);
        chk("key6_valid", {3'b0, keyValid}, 4'h1);
        chk("key6_held", {3'b0, keyHeld}, 4'h1);
        step("post_confirm", 1'b1, 4'b0010, 1'b0, 1'b0);
        chk("key6_pulse_end", {3'b0, keyValid}, 4'h0);

        // Release with a confirmed low; rotation resumes from the frozen column.
        for (int i = 0; i < 3; i++) step("release", 1'b1, 4'h0, 1'b0, 1'b0);
        step("release_low", 1'b1, 4'h0, 1'b0, 1'b1);
        chk("rel_held", {3'b0, keyHeld}, 4'h0);
        chk("rel_req", {3'b0, req}, 4'h0);
        chk("rel_col", activeCol, 4'b1011);
        step("resume", 1'b1, 4'h0, 1'b0, 1'b0);
        chk("resume_col", activeCol, 4'b0111);

        // Bounce: low during press debouncing leaves the key alone.
        step("b_sync_a", 1'b0, 4'b0001, 1'b0, 1'b0);
        step("b_sync_b", 1'b0, 4'b0001, 1'b0, 1'b0);
        step("b_detect", 1'b1, 4'b0001, 1'b0, 1'b0);
        step("b_low", 1'b1, 4'b0001, 1'b0, 1'b1);
        chk("bounce_key", key, 4'h6);
        chk("bounce_req", {3'b0, req}, 4'h0);
        step("b_flush_a", 1'b0, 4'h0, 1'b0, 1'b0);
        step("b_flush_b", 1'b0, 4'h0, 1'b0, 1'b0);
        chk("bounce_col", activeCol, 4'b0111);

        // Two rows at column 0: lowest row wins; high stretched across en=0 clocks.
        step("to_c0", 1'b1, 4'h0, 1'b0, 1'b0);
        chk("at_c0", activeCol, 4'b1110);
        step("m_sync_a", 1'b0, 4'b0110, 1'b0, 1'b0);
        step("m_sync_b", 1'b0, 4'b0110, 1'b0, 1'b0);
        step("m_detect", 1'b1, 4'b0110, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step("m_high_noen", 1'b0, 4'b0110, 1'b1, 1'b0);
        step("m_confirm", 1'b1, 4'b0110, 1'b1, 1'b0);
        chk("key4", key, 4'h4);
        chk("key4_valid", {3'b0, keyValid}, 4'h1);
        step("m_after", 1'b0, 4'b0110, 1'b1, 1'b0);
        chk("key4_pulse_end", {3'b0, keyValid}, 4'h0);

        // Reset while held.
        do_reset("rst_held");
        chk("rst_held_key", key, 4'h0);
        step("rst_resume", 1'b1, 4'h0, 1'b0, 1'b0);
        chk("rst_resume_col", activeCol, 4'b1101);

        // Randomised traffic with occasional mid-sequence resets.
        rs = 4'h0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0)
                rs = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            re = ($urandom_range(0, 3) != 0);
            rh = ($urandom_range(0, 7) == 0);
            rl = ($urandom_range(0, 7) == 0);
            step("rand", re, rs, rh, rl);
            if ($urandom_range(0, 499) == 0) begin
                do_reset("rand_rst");
                rs = 4'h0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter: none; the block is fully fixed-width.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset; asynchronous, active-low.
REQ-004 en  input  1  scan/step tick; the FSM and column rotation advance only on clk edges where en=1.
REQ-005 sense  input  4  raw keypad row lines, active-high pressed, asynchronous to clk.
REQ-006 senseSync  output  4  sense after the 2-flop synchronizer; feeds the debouncer col input.
REQ-007 activeCol  output  4  one-cold column drive; the low bit selects the driven column; also feeds the debouncer activeCol input.
REQ-008 req  output  1  debounce request to the debouncer; held high for the whole press/hold/release sequence.
REQ-009 high  input  1  debouncer: valid stable-high (press) confirmed.
REQ-010 low  input  1  debouncer: valid stable-low (release or bounce-off) confirmed.
REQ-011 key  output  4  hex code of the last confirmed key.
REQ-012 keyValid  output  1  one-clk pulse on a confirmed new press.
REQ-013 keyHeld  output  1  high while a confirmed key has not yet been released.

Function
REQ-014 sense SHALL pass through two flops clocked every clk, independent of en; senseSync is the second flop; all FSM decisions use senseSync.
REQ-015 FSM states: SCAN, PRESS (debouncing press), HELD, RELEASE (debouncing release); the encoding is an implementation choice.
REQ-016 SCAN, en=1, senseSync=0: activeCol SHALL rotate 1110->1101->1011->0111->1110 (column index c = 0,1,2,3,0).
REQ-017 SCAN, en=1, senseSync!=0: the FSM SHALL freeze activeCol, latch row r = index of the lowest set senseSync bit and the current c, go to PRESS, and assert req on the next cycle.
REQ-018 PRESS, en=1, high=1: the FSM SHALL load key=map(r,c), pulse keyValid for exactly one clk, and go to HELD.
REQ-019 PRESS, en=1, low=1: the event is a bounce; the FSM SHALL deassert req, leave key unchanged, return to SCAN, and resume rotation from the frozen column.
REQ-020 PRESS, high and low both 1: high SHALL win.
REQ-021 HELD: keyHeld=1 and req=1; on en=1 with senseSync=0, the FSM SHALL go to RELEASE.
REQ-022 RELEASE, en=1, low=1: the FSM SHALL clear keyHeld, deassert req, and go to SCAN.
REQ-023 RELEASE, en=1, high=1 (key re-pressed or bounce): the FSM SHALL return to HELD with no new keyValid.
REQ-024 While out of SCAN, activeCol SHALL stay frozen; additional keys in other rows or columns SHALL be ignored until SCAN is re-entered.
REQ-025 map(r,c), with r listed first and c = 0..3 within each row:
  r0: 1 2 3 A
  r1: 4 5 6 B
  r2: 7 8 9 C
  r3: E 0 F D
REQ-026 Cycles with en=0 SHALL leave the state, activeCol, key and keyHeld unchanged; high and low SHALL be ignored when en=0.
REQ-027 keyValid SHALL never assert for two consecutive clks and SHALL assert at most once per PRESS->HELD transition.
REQ-028 Press-to-keyValid latency: 2 clk (synchronizer) + 1 en-tick (SCAN->PRESS) + debouncer time + 1 en-tick.

Reset
REQ-029 rstn=0 SHALL take effect immediately, without waiting for clk.
REQ-030 Values on reset: state=SCAN, activeCol=1110, req=0, key=0000, keyValid=0, keyHeld=0, synchronizer flops=0000.
REQ-031 Reset asserted mid-sequence (PRESS, HELD or RELEASE) SHALL abort the sequence with no keyValid pulse.
REQ-032 After rstn rises, the block SHALL stay in SCAN and rotate normally on the next en tick.

Verification
REQ-033 en=1 every clk, sense=0 for 8 clks -> activeCol cycles 1110,1101,1011,0111,1110...; req=0.
REQ-034 Press r1 while activeCol=1011 (c=2); debouncer high=1 after 10 ticks -> exactly one keyValid pulse, key=6, keyHeld=1.
REQ-035 Release sense=0 in HELD; low=1 -> keyHeld=0, req=0, rotation resumes from 1011.
REQ-036 Press in PRESS followed by low=1 (bounce) -> no keyValid, key keeps its prior value, state returns to SCAN.
REQ-037 sense=0110 at c=0 -> key=4 (lowest row wins); high held for 5 clks with en=0 -> keyValid pulses once.
REQ-038 rstn pulsed low in HELD between clk edges -> outputs take their reset values immediately; no keyValid.
